// File: rtl/vm2002_coin_acceptor_if.sv
// Request/response bundle between the coin acceptor, its coin slot, the vend controller
// and the change dispenser. The master drives requests; the acceptor is the slave.
interface vm2002_coin_acceptor_if;
    logic        coin_valid;
    logic [1:0]  coin_type;
    logic        cancel;
    logic        vend_req;
    logic [15:0] vend_cost;
    logic        change_ready;

    logic [15:0] balance;
    logic        coin_accept;
    logic        coin_reject;
    logic        vend_ok;
    logic        vend_fail;
    logic        change_valid;
    logic [1:0]  change_coin;
    logic        busy;

    modport master (
        output coin_valid, coin_type, cancel, vend_req, vend_cost, change_ready,
        input  balance, coin_accept, coin_reject, vend_ok, vend_fail,
               change_valid, change_coin, busy
    );

    modport slave (
        input  coin_valid, coin_type, cancel, vend_req, vend_cost, change_ready,
        output balance, coin_accept, coin_reject, vend_ok, vend_fail,
               change_valid, change_coin, busy
    );
endinterface

// File: rtl/vm2002_coin_acceptor.sv
// Coin acceptor: credits coins up to MAX_CREDIT, debits vends and refunds credit one
// change coin at a time (largest denomination first). All outputs are registered.
module vm2002_coin_acceptor #(
    parameter logic [15:0] MAX_CREDIT = 16'd500
) (
    input logic                   clk,
    input logic                   rst_n,
    vm2002_coin_acceptor_if.slave bus
);

    typedef enum logic {StIdle, StRefund} state_e;

    state_e      r_state, w_state_d;
    logic [15:0] r_balance, w_balance_d;
    logic        r_coin_accept, w_coin_accept_d;
    logic        r_coin_reject, w_coin_reject_d;
    logic        r_vend_ok, w_vend_ok_d;
    logic        r_vend_fail, w_vend_fail_d;
    logic        r_change_valid, w_change_valid_d;
    logic [1:0]  r_change_coin, w_change_coin_d;
    logic        r_busy, w_busy_d;

    logic [16:0] w_coin_sum;
    logic        w_coin_fits;
    logic        w_cost_ok;
    logic [15:0] w_refund_left;

    function automatic logic [15:0] coin_value(input logic [1:0] coin);
        case (coin)
            2'd0:    coin_value = 16'd5;
            2'd1:    coin_value = 16'd10;
            2'd2:    coin_value = 16'd25;
            default: coin_value = 16'd100;
        endcase
    endfunction

    // Largest denomination not exceeding the credit; credit is always a nonzero multiple
    // of 5 when this is consulted, so the 5c fallback is exact.
    function automatic logic [1:0] largest_coin(input logic [15:0] credit);
        if (credit >= 16'd100) begin
            largest_coin = 2'd3;
        end else if (credit >= 16'd25) begin
            largest_coin = 2'd2;
        end else if (credit >= 16'd10) begin
            largest_coin = 2'd1;
        end else begin
            largest_coin = 2'd0;
        end
    endfunction

    assign w_coin_sum    = {1'b0, r_balance} + {1'b0, coin_value(bus.coin_type)};
    assign w_coin_fits   = (w_coin_sum <= {1'b0, MAX_CREDIT});
    assign w_cost_ok     = (bus.vend_cost != 16'd0) && ((bus.vend_cost % 16'd5) == 16'd0) &&
                           (bus.vend_cost <= r_balance);
    assign w_refund_left = r_balance - coin_value(r_change_coin);

    always_comb begin
        w_state_d        = r_state;
        w_balance_d      = r_balance;
        w_coin_accept_d  = 1'b0;
        w_coin_reject_d  = 1'b0;
        w_vend_ok_d      = 1'b0;
        w_vend_fail_d    = 1'b0;
        w_change_valid_d = r_change_valid;
        w_change_coin_d  = r_change_coin;

        case (r_state)
            StIdle: begin
                if (bus.vend_req) begin
                    // Vend wins against the pre-cycle balance; a same-cycle coin bounces.
                    w_coin_reject_d = bus.coin_valid;
                    if (w_cost_ok) begin
                        w_vend_ok_d = 1'b1;
                        w_balance_d = r_balance - bus.vend_cost;
                    end else begin
                        w_vend_fail_d = 1'b1;
                    end
                end else if (bus.cancel) begin
                    w_coin_reject_d = bus.coin_valid;
                    if (r_balance != 16'd0) begin
                        w_state_d        = StRefund;
                        w_change_valid_d = 1'b1;
                        w_change_coin_d  = largest_coin(r_balance);
                    end
                end else if (bus.coin_valid) begin
                    if (w_coin_fits) begin
                        w_coin_accept_d = 1'b1;
                        w_balance_d     = w_coin_sum[15:0];
                    end else begin
                        w_coin_reject_d = 1'b1;
                    end
                end
            end
            StRefund: begin
                w_coin_reject_d = bus.coin_valid;
                w_vend_fail_d   = bus.vend_req;
                if (r_change_valid && bus.change_ready) begin
                    w_balance_d = w_refund_left;
                    if (w_refund_left == 16'd0) begin
                        w_state_d        = StIdle;
                        w_change_valid_d = 1'b0;
                        w_change_coin_d  = 2'd0;
                    end else begin
                        w_change_coin_d = largest_coin(w_refund_left);
                    end
                end
            end
            default: begin
                w_state_d        = StIdle;
                w_change_valid_d = 1'b0;
                w_change_coin_d  = 2'd0;
            end
        endcase

        w_busy_d = (w_state_d == StRefund);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_balance      <= 16'd0;
            r_coin_accept  <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_vend_ok      <= 1'b0;
            r_vend_fail    <= 1'b0;
            r_change_valid <= 1'b0;
            r_change_coin  <= 2'd0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_balance      <= w_balance_d;
            r_coin_accept  <= w_coin_accept_d;
            r_coin_reject  <= w_coin_reject_d;
            r_vend_ok      <= w_vend_ok_d;
            r_vend_fail    <= w_vend_fail_d;
            r_change_valid <= w_change_valid_d;
            r_change_coin  <= w_change_coin_d;
            r_busy         <= w_busy_d;
        end
    end

    assign bus.balance      = r_balance;
    assign bus.coin_accept  = r_coin_accept;
    assign bus.coin_reject  = r_coin_reject;
    assign bus.vend_ok      = r_vend_ok;
    assign bus.vend_fail    = r_vend_fail;
    assign bus.change_valid = r_change_valid;
    assign bus.change_coin  = r_change_coin;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_vm2002_coin_acceptor.sv
// Bench for vm2002_coin_acceptor: directed scenarios plus random traffic, each cycle
// checked against a credit/refund model built from plain arithmetic.
module tb_vm2002_coin_acceptor;

    localparam int MAXC = 500;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    int   VALS[4] = '{5, 10, 25, 100};
    int   m_bal;
    bit   m_ref;
    logic [1:0] held_coin;

    vm2002_coin_acceptor_if bus_if ();

    vm2002_coin_acceptor #(
        .MAX_CREDIT(16'd500)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int largest_idx(input int credit);
        for (int i = 3; i >= 0; i--) begin
            if (VALS[i] <= credit) return i;
        end
        return 0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_balance"}, bus_if.balance, 16'd0);
        chk({tag, "_pulses"}, {12'd0, bus_if.coin_accept, bus_if.coin_reject,
                               bus_if.vend_ok, bus_if.vend_fail}, 16'd0);
        chk({tag, "_change_valid"}, {15'd0, bus_if.change_valid}, 16'd0);
        chk({tag, "_change_coin"}, {14'd0, bus_if.change_coin}, 16'd0);
        chk({tag, "_busy"}, {15'd0, bus_if.busy}, 16'd0);
    endtask

    // One clock of stimulus; the model predicts the registered outputs after the edge.
    task automatic step(input bit cv, input logic [1:0] ct, input bit can, input bit vr,
                        input logic [15:0] vc, input bit rdy);
        bit e_acc, e_rej, e_ok, e_fail;
        int cost;
        e_acc = 0; e_rej = 0; e_ok = 0; e_fail = 0;
        cost = int'(vc);
        @(negedge clk);
        bus_if.coin_valid   = cv;
        bus_if.coin_type    = ct;
        bus_if.cancel       = can;
        bus_if.vend_req     = vr;
        bus_if.vend_cost    = vc;
        bus_if.change_ready = rdy;
        if (!m_ref) begin
            if (vr) begin
                e_rej = cv;
                if (cost != 0 && cost % 5 == 0 && cost <= m_bal) begin
                    e_ok = 1; m_bal -= cost;
                end else begin
                    e_fail = 1;
                end
            end else if (can) begin
                e_rej = cv;
                if (m_bal > 0) m_ref = 1;
            end else if (cv) begin
                if (m_bal + VALS[ct] <= MAXC) begin
                    e_acc = 1; m_bal += VALS[ct];
                end else begin
                    e_rej = 1;
                end
            end
        end else begin
            e_rej  = cv;
            e_fail = vr;
            if (rdy) begin
                m_bal -= VALS[largest_idx(m_bal)];
                if (m_bal == 0) m_ref = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("balance", bus_if.balance, 16'(m_bal));
        chk("coin_accept", {15'd0, bus_if.coin_accept}, {15'd0, e_acc});
        chk("coin_reject", {15'd0, bus_if.coin_reject}, {15'd0, e_rej});
        chk("vend_ok", {15'd0, bus_if.vend_ok}, {15'd0, e_ok});
        chk("vend_fail", {15'd0, bus_if.vend_fail}, {15'd0, e_fail});
        chk("change_valid", {15'd0, bus_if.change_valid}, {15'd0, m_ref});
        chk("change_coin", {14'd0, bus_if.change_coin},
            m_ref ? 16'(largest_idx(m_bal)) : 16'd0);
        chk("busy", {15'd0, bus_if.busy}, {15'd0, m_ref});
        chk("bal_invariant", {15'd0, (bus_if.balance % 16'd5 == 16'd0) &&
                              (bus_if.balance <= 16'd500)}, 16'd1);
    endtask

    task automatic idle_inputs();
        bus_if.coin_valid   = 0;
        bus_if.coin_type    = 0;
        bus_if.cancel       = 0;
        bus_if.vend_req     = 0;
        bus_if.vend_cost    = 0;
        bus_if.change_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        m_bal = 0;
        m_ref = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic coin(input logic [1:0] ct);
        step(1, ct, 0, 0, 16'd0, 0);
    endtask

    task automatic vend(input logic [15:0] cost);
        step(0, 2'd0, 0, 1, cost, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_bal   = 0;
        m_ref   = 0;
        clk     = 0;
        rst_n   = 0;
        idle_inputs();
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // 25 + 25 + 100, then vend 125
        coin(2'd2); chk("s1_bal25", bus_if.balance, 16'd25);
        coin(2'd2); chk("s1_bal50", bus_if.balance, 16'd50);
        coin(2'd3); chk("s1_bal150", bus_if.balance, 16'd150);
        vend(16'd125);
        chk("s1_vend_ok", {15'd0, bus_if.vend_ok}, 16'd1);
        chk("s1_bal25_after", bus_if.balance, 16'd25);

        // Fill to 480, overflowing coin rejected, 10c accepted
        do_reset();
        repeat (4) coin(2'd3);
        repeat (3) coin(2'd2);
        coin(2'd0);
        chk("s2_bal480", bus_if.balance, 16'd480);
        coin(2'd2);
        chk("s2_reject25", {15'd0, bus_if.coin_reject}, 16'd1);
        chk("s2_bal_held", bus_if.balance, 16'd480);
        coin(2'd1);
        chk("s2_accept10", {15'd0, bus_if.coin_accept}, 16'd1);
        chk("s2_bal490", bus_if.balance, 16'd490);
        coin(2'd1);
        chk("s2_bal500", bus_if.balance, 16'd500);

        // Invalid vends at balance 40
        do_reset();
        coin(2'd2); coin(2'd1); coin(2'd0);
        chk("s3_bal40", bus_if.balance, 16'd40);
        vend(16'd45); chk("s3_fail45", {15'd0, bus_if.vend_fail}, 16'd1);
        chk("s3_bal_keep", bus_if.balance, 16'd40);
        vend(16'd0);  chk("s3_fail0", {15'd0, bus_if.vend_fail}, 16'd1);
        vend(16'd33); chk("s3_fail33", {15'd0, bus_if.vend_fail}, 16'd1);
        vend(16'd40); chk("s3_ok40", bus_if.balance, 16'd0);
        step(0, 2'd0, 1, 0, 16'd0, 0);
        chk("s3_cancel_zero_ignored", {15'd0, bus_if.busy}, 16'd0);

        // Refund of 140 with dispenser always ready
        do_reset();
        coin(2'd3); coin(2'd2); coin(2'd1); coin(2'd0);
        step(0, 2'd0, 1, 0, 16'd0, 1);
        chk("s4_coin100", {14'd0, bus_if.change_coin}, 16'd3);
        step(0, 2'd0, 0, 0, 16'd0, 1);
        chk("s4_coin25", {14'd0, bus_if.change_coin}, 16'd2);
        step(0, 2'd0, 0, 0, 16'd0, 1);
        chk("s4_coin10", {14'd0, bus_if.change_coin}, 16'd1);
        step(0, 2'd0, 0, 0, 16'd0, 1);
        chk("s4_coin5", {14'd0, bus_if.change_coin}, 16'd0);
        chk("s4_valid5", {15'd0, bus_if.change_valid}, 16'd1);
        step(0, 2'd0, 0, 0, 16'd0, 1);
        chk("s4_done_busy", {15'd0, bus_if.busy}, 16'd0);
        chk("s4_done_bal", bus_if.balance, 16'd0);

        // Stalled dispenser: coin held, coin/vend/cancel during refund bounce
        coin(2'd3); coin(2'd2);
        step(0, 2'd0, 1, 0, 16'd0, 0);
        held_coin = bus_if.change_coin;
        chk("s5_first_coin", {14'd0, held_coin}, 16'd3);
        for (int i = 0; i < 5; i++) begin
            step(i == 2, 2'd1, i == 3, i == 4, 16'd5, 0);
            chk("s5_hold_coin", {14'd0, bus_if.change_coin}, {14'd0, held_coin});
            chk("s5_hold_bal", bus_if.balance, 16'd125);
            if (i == 2) chk("s5_coin_rej", {15'd0, bus_if.coin_reject}, 16'd1);
            if (i == 4) chk("s5_vend_rej", {15'd0, bus_if.vend_fail}, 16'd1);
        end

        // Reset in the middle of the refund: asynchronous clear
        step(0, 2'd0, 0, 0, 16'd0, 1);
        chk("s7_mid_refund", {15'd0, bus_if.busy}, 16'd1);
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs("async_rst");
        m_bal = 0;
        m_ref = 0;
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        coin(2'd0);
        chk("s7_post_rst_accept", {15'd0, bus_if.coin_accept}, 16'd1);

        // Simultaneous vend 50 and coin 25 at balance 50
        do_reset();
        coin(2'd2); coin(2'd2);
        step(1, 2'd2, 0, 1, 16'd50, 0);
        chk("s6_vend_ok", {15'd0, bus_if.vend_ok}, 16'd1);
        chk("s6_coin_rej", {15'd0, bus_if.coin_reject}, 16'd1);
        chk("s6_bal0", bus_if.balance, 16'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] rc;
            if ($urandom_range(0, 3) == 0) rc = 16'($urandom_range(0, 200));
            else rc = 16'($urandom_range(0, 40) * 5);
            step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, rc,
                 $urandom_range(0, 1) == 1);
        end

        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vm2002_coin_acceptor.md
VM2002_COIN_ACCEPTOR -- requirements
Module: vm2002_coin_acceptor

Interface
REQ-001 Parameter MAX_CREDIT, default 16'd500, maximum credit held in cents; must be a multiple of 5 and at most 16'hFFFF.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 coin_valid  input  1  one coin presented this cycle.
REQ-005 coin_type  input  2  coin denomination: 0 = 5c, 1 = 10c, 2 = 25c, 3 = 100c.
REQ-006 cancel  input  1  user requests refund of all credit.
REQ-007 vend_req  input  1  downstream vend controller requests a purchase this cycle.
REQ-008 vend_cost  input  16  price in cents for vend_req.
REQ-009 change_ready  input  1  coin dispenser accepts the presented change coin.
REQ-010 balance  output  16  current credit in cents, registered.
REQ-011 coin_accept  output  1  one-cycle pulse: the coin was credited.
REQ-012 coin_reject  output  1  one-cycle pulse: the coin was returned uncredited.
REQ-013 vend_ok  output  1  one-cycle pulse: vend_cost was debited.
REQ-014 vend_fail  output  1  one-cycle pulse: vend refused, balance unchanged.
REQ-015 change_valid  output  1  change coin presented to the dispenser.
REQ-016 change_coin  output  2  denomination of the presented change coin, same encoding as coin_type.
REQ-017 busy  output  1  high while in state REFUND.

Function
REQ-018 The block SHALL have two states, IDLE and REFUND, and all outputs SHALL be registered.
REQ-019 coin_accept, coin_reject, vend_ok and vend_fail SHALL appear one cycle after the sampled request, together with the updated balance.
REQ-020 IDLE, coin_valid=1, vend_req=0: if balance plus the coin value is at most MAX_CREDIT, the block SHALL add the value to balance and pulse coin_accept; otherwise it SHALL pulse coin_reject and leave balance unchanged.
REQ-021 IDLE, vend_req=1: the block SHALL pulse vend_ok and set balance to balance minus vend_cost when vend_cost is nonzero, a multiple of 5 and at most balance; in every other case it SHALL pulse vend_fail.
REQ-022 Simultaneous vend_req and coin_valid: the vend SHALL be evaluated against the pre-cycle balance, and the coin SHALL be rejected (coin_reject).
REQ-023 Priority within IDLE SHALL be vend_req first, then cancel, then coin_valid; a lower-priority coin in the same cycle is rejected.
REQ-024 IDLE, cancel=1 with no vend_req: if balance is nonzero the block SHALL enter REFUND next cycle; if balance is zero, cancel SHALL be ignored.
REQ-025 In REFUND, the block SHALL assert change_valid, with change_coin set to the largest denomination (100, 25, 10, 5) not exceeding balance.
REQ-026 In REFUND, change_coin SHALL be held stable while change_valid=1 and change_ready=0.
REQ-027 In REFUND, on change_valid and change_ready both high, the block SHALL subtract the coin value from balance in the same edge.
REQ-028 When that subtraction reaches 0, the block SHALL return to IDLE and deassert change_valid and busy on the same edge.
REQ-029 In REFUND, any coin_valid SHALL pulse coin_reject, any vend_req SHALL pulse vend_fail, and cancel SHALL be ignored.
REQ-030 balance SHALL always be a multiple of 5 and at most MAX_CREDIT, and SHALL never wrap or underflow.
REQ-031 The pulse outputs SHALL never be high for two consecutive cycles from a single-cycle request.

Reset
REQ-032 While rst=0: balance=0, all pulse outputs=0, change_valid=0, change_coin=0, busy=0, state=IDLE, applied asynchronously.
REQ-033 Reset asserted mid-REFUND SHALL abort the refund immediately; the remaining credit is discarded and change_valid drops without waiting for a clock.
REQ-034 Deassertion of rst SHALL take effect at a clock edge; the first request SHALL be sampled on the first rising edge after release.

Verification
REQ-035 Directed scenarios:
- Coins 25, 25, 100, then vend_req with cost 125 -> balance steps 25, 50, 150; vend_ok; balance=25.
- balance=480, MAX_CREDIT=500, coin 25 -> coin_reject, balance=480; then coin 10 -> coin_accept, balance=490.
- balance=40, vend_req with cost 45 -> vend_fail, balance=40; vend_req with cost 0 -> vend_fail; vend_req with cost 33 -> vend_fail.
- balance=140, cancel, change_ready always 1 -> change_coin sequence 100, 25, 10, 5, then busy=0 and balance=0.
- In REFUND with change_ready=0 for 5 cycles -> change_coin stable and balance unchanged; a coin_valid in that window -> coin_reject.
- Same cycle: vend_req with cost 50, coin 25, balance 50 -> vend_ok, coin_reject, balance=0.
- Reset pulse in the middle of REFUND -> all outputs at reset values asynchronously, state IDLE after release.
